axi_wr_chan_fifo: RTL and testbench

- Parametrised AXI4 write-address/write-data buffer between the cache write path and the AXI master port.
- Holds separate AW and W queues, each with a full valid/ready handshake on both sides and first-word-fall-through outputs.
- Optional packet mode holds back an AW request until all of its W beats (through WLAST) are buffered, so the downstream master never stalls mid-burst.
- Provides occupancy, almost-full and an over-length error flag.

---
 rtl/axi_wr_chan_fifo.sv | 149 ++++++++++++++
 tb/tb_axi_wr_chan_fifo.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_chan_fifo.sv
// AXI4 AW/W buffer between the cache write path and the AXI master port.
// Two FWFT queues; packet mode holds AW until its whole burst is buffered.
module axi_wr_chan_fifo #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int ID_WIDTH    = 4,
  parameter int AW_DEPTH    = 4,
  parameter int W_DEPTH     = 16,
  parameter int W_AFULL     = 12,
  parameter int PACKET_MODE = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic [ID_WIDTH-1:0]            s_awid,
  input  logic [7:0]                     s_awlen,
  input  logic [2:0]                     s_awsize,
  input  logic [1:0]                     s_awburst,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wlast,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [ADDR_WIDTH-1:0]          m_awaddr,
  output logic [ID_WIDTH-1:0]            m_awid,
  output logic [7:0]                     m_awlen,
  output logic [2:0]                     m_awsize,
  output logic [1:0]                     m_awburst,
  output logic                           m_awvalid,
  input  logic                           m_awready,
  output logic [DATA_WIDTH-1:0]          m_wdata,
  output logic [DATA_WIDTH/8-1:0]        m_wstrb,
  output logic                           m_wlast,
  output logic                           m_wvalid,
  input  logic                           m_wready,
  output logic [$clog2(AW_DEPTH+1)-1:0]  aw_count,
  output logic [$clog2(W_DEPTH+1)-1:0]   w_count,
  output logic                           w_afull,
  output logic                           err_overlen
);

  localparam int AP  = $clog2(AW_DEPTH);
  localparam int WP  = $clog2(W_DEPTH);
  localparam int AWB = ADDR_WIDTH + ID_WIDTH + 13;
  localparam int WB  = DATA_WIDTH + DATA_WIDTH/8 + 1;
  localparam int WCW = $clog2(W_DEPTH+1);

  logic [AWB-1:0] aw_mem [AW_DEPTH];
  logic [WB-1:0]  w_mem  [W_DEPTH];
  logic [AP:0]    aw_wr, aw_rd;
  logic [WP:0]    w_wr, w_rd;
  logic [WCW-1:0] cmpl, issued;
  logic           err_q;
  logic           aw_full, aw_empty, w_full, w_empty;
  logic           aw_push, aw_pop, w_push, w_pop;
  logic           overlen;

  assign aw_full  = (aw_wr[AP] != aw_rd[AP]) &&
                    (aw_wr[AP-1:0] == aw_rd[AP-1:0]);
  assign aw_empty = aw_wr == aw_rd;
  assign w_full   = (w_wr[WP] != w_rd[WP]) &&
                    (w_wr[WP-1:0] == w_rd[WP-1:0]);
  assign w_empty  = w_wr == w_rd;

  assign s_awready = !aw_full;
  assign s_wready  = !w_full;

  assign m_awvalid = !aw_empty &&
                     ((PACKET_MODE == 0) || (cmpl != '0));
  assign m_wvalid  = !w_empty &&
                     ((PACKET_MODE == 0) || (issued != '0));

  assign aw_push = s_awvalid && s_awready;
  assign aw_pop  = m_awvalid && m_awready;
  assign w_push  = s_wvalid && s_wready;
  assign w_pop   = m_wvalid && m_wready;

  assign {m_awaddr, m_awid, m_awlen, m_awsize, m_awburst} =
    aw_mem[aw_rd[AP-1:0]];
  assign {m_wdata, m_wstrb, m_wlast} = w_mem[w_rd[WP-1:0]];

  assign aw_count = aw_wr - aw_rd;
  assign w_count  = w_wr - w_rd;
  assign w_afull  = w_count >= WCW'(W_AFULL);

  // A full W queue with no complete or issued burst can never drain.
  assign overlen = (PACKET_MODE != 0) && w_full &&
                   (cmpl == '0) && (issued == '0);
  assign err_overlen = err_q | overlen;

  // Queue storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (aw_push)
      aw_mem[aw_wr[AP-1:0]] <=
        {s_awaddr, s_awid, s_awlen, s_awsize, s_awburst};
    if (w_push)
      w_mem[w_wr[WP-1:0]] <= {s_wdata, s_wstrb, s_wlast};
  end

  // Read/write pointers with wrap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wr <= '0;
      aw_rd <= '0;
      w_wr  <= '0;
      w_rd  <= '0;
    end else begin
      if (aw_push) aw_wr <= aw_wr + 1'b1;
      if (aw_pop)  aw_rd <= aw_rd + 1'b1;
      if (w_push)  w_wr  <= w_wr + 1'b1;
      if (w_pop)   w_rd  <= w_rd + 1'b1;
    end
  end

  // Bursts fully buffered but not yet announced on AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmpl <= '0;
    end else begin
      case ({w_push && s_wlast, aw_pop})
        2'b10:   cmpl <= cmpl + WCW'(1);
        2'b01:   cmpl <= cmpl - WCW'(1);
        default: cmpl <= cmpl;
      endcase
    end
  end

  // Bursts announced on AW whose last beat has not left yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued <= '0;
    end else begin
      case ({aw_pop, w_pop && m_wlast})
        2'b10:   issued <= issued + WCW'(1);
        2'b01:   issued <= issued - WCW'(1);
        default: issued <= issued;
      endcase
    end
  end

  // Sticky over-length flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (overlen) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_axi_wr_chan_fifo.sv
// Bench for axi_wr_chan_fifo: packet-mode and plain instances share stimulus,
// each checked every cycle against a queue-based reference model.
module tb_axi_wr_chan_fifo;

  localparam int AD = 4;
  localparam int WD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        m_awready;
  logic        m_wready;

  logic        o_awready [2];
  logic        o_wready  [2];
  logic [31:0] o_awaddr  [2];
  logic [3:0]  o_awid    [2];
  logic [7:0]  o_awlen   [2];
  logic [2:0]  o_awsize  [2];
  logic [1:0]  o_awburst [2];
  logic        o_awvalid [2];
  logic [63:0] o_wdata   [2];
  logic [7:0]  o_wstrb   [2];
  logic        o_wlast   [2];
  logic        o_wvalid  [2];
  logic [2:0]  o_awcnt   [2];
  logic [4:0]  o_wcnt    [2];
  logic        o_afull   [2];
  logic        o_err     [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_wr_chan_fifo #(
      .AW_DEPTH(AD),
      .W_DEPTH(WD),
      .W_AFULL(12),
      .PACKET_MODE(g == 0 ? 1 : 0)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_awaddr(awaddr),
      .s_awid(awid),
      .s_awlen(awlen),
      .s_awsize(awsize),
      .s_awburst(awburst),
      .s_awvalid(awvalid),
      .s_awready(o_awready[g]),
      .s_wdata(wdata),
      .s_wstrb(wstrb),
      .s_wlast(wlast),
      .s_wvalid(wvalid),
      .s_wready(o_wready[g]),
      .m_awaddr(o_awaddr[g]),
      .m_awid(o_awid[g]),
      .m_awlen(o_awlen[g]),
      .m_awsize(o_awsize[g]),
      .m_awburst(o_awburst[g]),
      .m_awvalid(o_awvalid[g]),
      .m_awready(m_awready),
      .m_wdata(o_wdata[g]),
      .m_wstrb(o_wstrb[g]),
      .m_wlast(o_wlast[g]),
      .m_wvalid(o_wvalid[g]),
      .m_wready(m_wready),
      .aw_count(o_awcnt[g]),
      .w_count(o_wcnt[g]),
      .w_afull(o_afull[g]),
      .err_overlen(o_err[g])
    );
  end

  // Reference model: index 0 = packet mode, 1 = plain FIFOs.
  logic [48:0] aq [2][$];
  logic [72:0] wq [2][$];
  int          wl_push [2];
  int          aw_pops [2];
  int          wl_pops [2];
  bit          sticky  [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int k,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h",
             tag, k, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      aq[k].delete();
      wq[k].delete();
      wl_push[k] = 0;
      aw_pops[k] = 0;
      wl_pops[k] = 0;
      sticky[k]  = 1'b0;
    end
  endtask

  task automatic set_idle();
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    awaddr    = '0;
    awid      = '0;
    awlen     = '0;
    awsize    = 3'd3;
    awburst   = 2'd1;
    wdata     = '0;
    wstrb     = 8'hff;
  endtask

  // Called at a falling edge with inputs set; checks, updates model,
  // and returns at the next falling edge.
  task automatic cycle();
    int cm, is;
    bit eawr, ewr, eawv, ewv, err;
    #1;
    for (int k = 0; k < 2; k++) begin
      cm   = wl_push[k] - aw_pops[k];
      is   = aw_pops[k] - wl_pops[k];
      eawr = aq[k].size() < AD;
      ewr  = wq[k].size() < WD;
      eawv = aq[k].size() != 0 && (k == 1 || cm != 0);
      ewv  = wq[k].size() != 0 && (k == 1 || is != 0);
      err  = sticky[k] ||
             (k == 0 && wq[k].size() == WD && cm == 0 && is == 0);
      chk("s_awready", k, 128'(o_awready[k]), 128'(eawr));
      chk("s_wready", k, 128'(o_wready[k]), 128'(ewr));
      chk("m_awvalid", k, 128'(o_awvalid[k]), 128'(eawv));
      chk("m_wvalid", k, 128'(o_wvalid[k]), 128'(ewv));
      chk("aw_count", k, 128'(o_awcnt[k]), 128'(aq[k].size()));
      chk("w_count", k, 128'(o_wcnt[k]), 128'(wq[k].size()));
      chk("w_afull", k, 128'(o_afull[k]), 128'(wq[k].size() >= 12));
      chk("err_overlen", k, 128'(o_err[k]), 128'(err));
      if (eawv)
        chk("aw_head", k,
            128'({o_awaddr[k], o_awid[k], o_awlen[k],
                  o_awsize[k], o_awburst[k]}),
            128'(aq[k][0]));
      if (ewv)
        chk("w_head", k,
            128'({o_wdata[k], o_wstrb[k], o_wlast[k]}),
            128'(wq[k][0]));
      sticky[k] = err;
      if (ewv && m_wready) begin
        if (wq[k][0][0]) wl_pops[k]++;
        void'(wq[k].pop_front());
      end
      if (eawv && m_awready) begin
        aw_pops[k]++;
        void'(aq[k].pop_front());
      end
      if (awvalid && eawr)
        aq[k].push_back({awaddr, awid, awlen, awsize, awburst});
      if (wvalid && ewr) begin
        wq[k].push_back({wdata, wstrb, wlast});
        if (wlast) wl_push[k]++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset between edges; outputs must react at once.
  task automatic reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_m_awvalid", k, 128'(o_awvalid[k]), 128'(0));
      chk("rst_m_wvalid", k, 128'(o_wvalid[k]), 128'(0));
      chk("rst_s_awready", k, 128'(o_awready[k]), 128'(1));
      chk("rst_s_wready", k, 128'(o_wready[k]), 128'(1));
      chk("rst_aw_count", k, 128'(o_awcnt[k]), 128'(0));
      chk("rst_w_count", k, 128'(o_wcnt[k]), 128'(0));
      chk("rst_w_afull", k, 128'(o_afull[k]), 128'(0));
      chk("rst_err", k, 128'(o_err[k]), 128'(0));
    end
    model_clear();
    set_idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    set_idle();
    model_clear();
    @(negedge clk);
    reset_mid();

    // Single burst: AW 0x1000 len 3, then four beats.
    awaddr = 32'h1000; awid = 4'd1; awlen = 8'd3;
    awvalid = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    cycle();
    awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wvalid = 1'b1;
      wdata  = 64'(i);
      wlast  = (i == 3);
      cycle();
    end
    wvalid = 1'b0; wlast = 1'b0;
    repeat (8) cycle();

    // Fill to full with no drain, then drain while pushing across wrap.
    set_idle();
    wvalid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wdata = 64'(100 + i);
      cycle();
    end
    m_wready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wdata = 64'(200 + i);
      cycle();
    end
    wvalid = 1'b0;
    repeat (20) cycle();
    reset_mid();

    // Back-pressure on two queued AW entries.
    awvalid = 1'b1; awaddr = 32'hA000_0040; awid = 4'd5; awlen = 8'd1;
    cycle();
    awaddr = 32'hB000_0080; awid = 4'd9; awlen = 8'd0;
    cycle();
    awvalid = 1'b0;
    repeat (5) cycle();
    m_awready = 1'b1;
    repeat (4) cycle();
    reset_mid();

    // Over-length burst: beats never carry wlast.
    awvalid = 1'b1; awlen = 8'd31; m_awready = 1'b1; m_wready = 1'b1;
    cycle();
    awvalid = 1'b0;
    wvalid  = 1'b1;
    for (int i = 0; i < 22; i++) begin
      wdata = {$urandom, $urandom};
      cycle();
    end
    wvalid = 1'b0;
    repeat (3) cycle();
    reset_mid();

    // Reset with 3 AW and 7 W entries queued.
    for (int i = 0; i < 7; i++) begin
      awvalid = (i < 3);
      awaddr  = $urandom;
      wvalid  = 1'b1;
      wdata   = {$urandom, $urandom};
      wlast   = (i == 6);
      cycle();
    end
    set_idle();
    cycle();
    reset_mid();

    // Randomised traffic in blocks separated by resets.
    for (int b = 0; b < 6; b++) begin
      for (int n = 0; n < 400; n++) begin
        awvalid   = ($urandom % 2) == 0;
        awaddr    = $urandom;
        awid      = 4'($urandom);
        awlen     = 8'($urandom % 8);
        awsize    = 3'($urandom);
        awburst   = 2'($urandom);
        wvalid    = ($urandom % 3) != 0;
        wdata     = {$urandom, $urandom};
        wstrb     = 8'($urandom);
        wlast     = ($urandom % 3) == 0;
        m_awready = ($urandom % 4) != 0;
        m_wready  = ($urandom % (2 + b % 3)) != 0;
        cycle();
      end
      reset_mid();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
